// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

endpackage

// File: rtl/rca32.sv
// 32-bit ripple-carry adder with carry-out and signed-overflow flag.
module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow
);

  logic [32:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[32];
  assign overflow  = carry[32] ^ carry[31];

endmodule

// File: rtl/mult32_seq.sv
// Unsigned 32x32->64 multiplier: one partial-product add per clock through a
// single shared rca32, with valid/ready handshakes on both sides.
module mult32_seq #(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 hi_nonzero
);
  import mult_pkg::*;

  if (WIDTH != 32) begin : g_width_check
    $error("mult32_seq supports only WIDTH == 32 (fixed by rca32)");
  end

  mult_state_t      state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             unused_overflow;

  // The multiplier LSB sits at acc_lo[0] and selects this cycle's partial product.
  assign addend = acc_lo[0] ? mcand : '0;

  rca32 u_adder (
    .a        (acc_hi),
    .b        (addend),
    .carry_in (1'b0),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (unused_overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          // carry_out becomes the new MSB so acc_hi + mcand never loses bit 32.
          {acc_hi, acc_lo} <= {carry_out, sum, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign product    = {acc_hi, acc_lo};
  assign hi_nonzero = |acc_hi;

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: directed cases plus randomized operands
// checked every cycle against a cycle-level behavioural model.
module tb_mult32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        hi_nonzero;

  int tests_run = 0;
  int tests_failed = 0;
  bit checking = 0;

  mult32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .hi_nonzero(hi_nonzero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Behavioural model: an accepted pair becomes visible as a*b exactly 32
  // edges later and stays until the downstream takes it.
  bit          m_idle = 1;
  bit          m_done = 0;
  int          m_wait = 0;
  logic [63:0] m_exp  = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle = 1;
      m_done = 0;
      m_wait = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_exp  = 64'(a) * 64'(b);
        m_wait = 32;
        m_idle = 0;
      end
    end else if (!m_done) begin
      m_wait--;
      if (m_wait == 0) m_done = 1;
    end else if (out_ready) begin
      m_done = 0;
      m_idle = 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("in_ready", 64'(in_ready), 64'(m_idle));
      checkOutput("out_valid", 64'(out_valid), 64'(m_done));
      if (m_done) begin
        checkOutput("model_product", product, m_exp);
        checkOutput("model_hi_nonzero", 64'(hi_nonzero), 64'(m_exp[63:32] != 0));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
    in_valid = 1;
    a = av;
    b = bv;
  endtask

  task automatic waitReady(input string name);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!in_ready) checkOutput({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  task automatic waitValid(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) checkOutput({name, "_valid_timeout"}, 64'(out_valid), 64'd1);
  endtask

  // Runs one operation and pins latency and result to hand-computed values.
  task automatic runOp(input string name, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp_prod, input logic exp_hi);
    int lat;
    out_ready = 0;
    applyStimulus(av, bv);
    waitReady(name);
    tick();
    in_valid = 0;
    a = $urandom;
    b = $urandom;
    waitValid(name, lat);
    checkOutput({name, "_latency"}, 64'(lat), 64'd32);
    checkOutput({name, "_product"}, product, exp_prod);
    checkOutput({name, "_hi_nonzero"}, 64'(hi_nonzero), 64'(exp_hi));
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    int lat;
    int guard;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 0;
    in_valid = 1;
    out_ready = 0;
    a = 32'h1111_1111;
    b = 32'h2222_2222;

    // Reset with in_valid asserted must not accept anything.
    tick();
    checking = 1;
    tick();
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_product", product, 64'd0);
    checkOutput("reset_hi_nonzero", 64'(hi_nonzero), 64'd0);
    in_valid = 0;
    rst_n = 1;
    tick();
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

    runOp("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    runOp("times_zero", 32'h1234_5678, 32'h0, 64'h0, 1'b0);
    runOp("one_times", 32'h1, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF, 1'b0);
    runOp("pow16_sq", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);

    // Backpressure: result held while a new pair waits upstream.
    out_ready = 0;
    applyStimulus(32'd7, 32'd6);
    waitReady("bp");
    tick();
    in_valid = 0;
    waitValid("bp", lat);
    applyStimulus(32'd9, 32'd11);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_hold_product", product, 64'h2A);
      checkOutput("bp_hold_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("bp_new_accepted", 64'(in_ready), 64'd0);
    in_valid = 0;
    waitValid("bp_next", lat);
    checkOutput("bp_next_latency", 64'(lat), 64'd32);
    checkOutput("bp_next_product", product, 64'd99);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Reset in the middle of an operation discards it.
    applyStimulus(32'hDEAD_BEEF, 32'hCAFE_BABE);
    waitReady("midrst");
    tick();
    in_valid = 0;
    for (int i = 0; i < 15; i++) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      checkOutput("midrst_no_output", 64'(out_valid), 64'd0);
    end
    runOp("after_rst", 32'd3, 32'd5, 64'd15, 1'b0);

    // Random operands with upstream noise during BUSY and random downstream stalls.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0: ra = 32'hFFFF_FFFF;
        1: ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: rb = 32'hFFFF_FFFF;
        1: rb = 32'h0;
        default: rb = $urandom;
      endcase
      applyStimulus(ra, rb);
      waitReady("rand");
      tick();
      guard = 0;
      while (!out_valid && guard < 100) begin
        in_valid = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        out_ready = 1'($urandom_range(0, 1));
        tick();
        guard++;
      end
      if (!out_valid) checkOutput("rand_valid_timeout", 64'(out_valid), 64'd1);
      in_valid = 0;
      guard = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        guard++;
      end while (out_valid && guard < 50);
      if (out_valid) checkOutput("rand_drain_timeout", 64'(out_valid), 64'd0);
      out_ready = 0;
    end

    tick();
    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
